// File: rtl/ps2_paddle_tracker_pkg.sv
// Shared scancodes, receiver states and paddle width for the PS/2 paddle tracker.
// Optional odd-parity checking is enabled with PS2_PARITY_CHK_EN.
package ps2_paddle_tracker_pkg;

  localparam int PADDLE_W = 9;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_S  = 8'h1B;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DN = 8'h72;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic w;
    logic s;
    logic up;
    logic dn;
  } keys_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input sync, falling-edge detect, frame FSM, timeout.
// Parity is only enforced when PS2_PARITY_CHK_EN is defined.
module ps2_rx_frame
  import ps2_paddle_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       fall, bit_in, par_ok;

  rx_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

`ifdef PS2_PARITY_CHK_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (fall && state_q == RX_PARITY) begin
      par_q <= bit_in;
    end
  end

  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == RX_IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
    if (fall) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!bit_in) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          if (bit_in && par_ok) vld_d = 1'b1;
          else                  err_d = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo_q == TMO_LAST) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign byte_o      = shift_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_paddle_tracker.sv
// Decodes PS/2 make/break codes into held keys and integrates two paddles.
// Odd-parity enforcement in the receiver is selected by PS2_PARITY_CHK_EN.
module ps2_paddle_tracker
  import ps2_paddle_tracker_pkg::*;
#(
  parameter int PADDLE_MIN  = 0,
  parameter int PADDLE_MAX  = 400,
  parameter int PADDLE_INIT = 200,
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 500000,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [PADDLE_W-1:0] paddle1,
  output logic [PADDLE_W-1:0] paddle2,
  output logic                frame_err
);

  localparam int XW = PADDLE_W + 1;
  localparam logic [XW-1:0] MIN_X  = XW'(PADDLE_MIN);
  localparam logic [XW-1:0] MAX_X  = XW'(PADDLE_MAX);
  localparam logic [XW-1:0] STEP_X = XW'(STEP);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [7:0] rx_byte;
  logic       byte_vld;

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld),
    .frame_err_o(frame_err)
  );

  logic  ext_q, ext_d, brk_q, brk_d;
  keys_t keys_q, keys_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic  tick;
  logic [PADDLE_W-1:0] p1_q, p1_d, p2_q, p2_d;

  // Widened by one bit so the saturation compares cannot wrap.
  function automatic logic [PADDLE_W-1:0] move(
    input logic [PADDLE_W-1:0] pos,
    input logic                up,
    input logic                dn
  );
    logic [XW-1:0] p;
    p    = {1'b0, pos};
    move = pos;
    if (up && !dn) begin
      move = (p < MIN_X + STEP_X) ? PADDLE_W'(MIN_X)
                                  : PADDLE_W'(p - STEP_X);
    end else if (dn && !up) begin
      move = (p > MAX_X - STEP_X) ? PADDLE_W'(MAX_X)
                                  : PADDLE_W'(p + STEP_X);
    end
  endfunction

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    if (byte_vld) begin
      unique case (1'b1)
        (rx_byte == SC_E0): ext_d = 1'b1;
        (rx_byte == SC_F0): brk_d = 1'b1;
        default: begin
          unique case ({ext_q, rx_byte})
            {1'b0, SC_W}:  keys_d.w  = ~brk_q;
            {1'b0, SC_S}:  keys_d.s  = ~brk_q;
            {1'b1, SC_UP}: keys_d.up = ~brk_q;
            {1'b1, SC_DN}: keys_d.dn = ~brk_q;
            default: ;
          endcase
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    p1_d = p1_q;
    p2_d = p2_q;
    if (tick) begin
      p1_d = move(p1_q, keys_q.w, keys_q.s);
      p2_d = move(p2_q, keys_q.up, keys_q.dn);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      keys_q     <= '0;
      tick_cnt_q <= '0;
      p1_q       <= PADDLE_W'(PADDLE_INIT);
      p2_q       <= PADDLE_W'(PADDLE_INIT);
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      keys_q     <= keys_d;
      tick_cnt_q <= tick_cnt_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
    end
  end

  assign paddle1 = p1_q;
  assign paddle2 = p2_q;

endmodule

// File: tb/tb_ps2_paddle_tracker.sv
// Directed bench for ps2_paddle_tracker (TICK_DIV=10, TIMEOUT_CYC=50, 40-clk PS/2 bit).
// Movement is checked over exact 50-cycle windows, which always contain five ticks.
module tb_ps2_paddle_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] paddle1, paddle2;
  logic       frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  int max_p2 = 0;

  ps2_paddle_tracker #(
    .TICK_DIV   (10),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .paddle1  (paddle1),
    .paddle2  (paddle2),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && frame_err) fe_cnt++;
  always @(negedge clk) if (int'(paddle2) > max_p2) max_p2 = int'(paddle2);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(20);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic par_good,
                      input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par_good ? ~^d : ^d);
    ps2_bit(stop);
    ps2_data = 1'b1;
    cyc(20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(5);
  endtask

  initial begin
    int a, b, c, f0, e;
    cyc(3);
    chk("rst_p1", int'(paddle1), 200);
    chk("rst_p2", int'(paddle2), 200);
    chk("rst_fe", int'(frame_err), 0);
    rst = 1'b1;
    cyc(5);

    // reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_p1", int'(paddle1), 200);
    chk("midrst_p2", int'(paddle2), 200);
    chk("midrst_fe", int'(frame_err), 0);
    ps2_data = 1'b1;
    cyc(5);
    rst = 1'b1;
    f0 = fe_cnt;
    cyc(150);
    chk("midrst_no_err", fe_cnt - f0, 0);

    // W make after release: up 4 per tick, then saturate at 0
    send(8'h1D, 1'b1, 1'b1);
    cyc(10);
    a = int'(paddle1);
    cyc(50);
    chk("w_up_5ticks", int'(paddle1), a - 20);
    chk("w_p2_idle", int'(paddle2), 200);
    cyc(100);
    send(8'hF0, 1'b1, 1'b1);
    chk("w_sat_min", int'(paddle1), 0);
    send(8'h1D, 1'b1, 1'b1);
    cyc(10);
    c = int'(paddle1);
    cyc(100);
    chk("w_break_hold", int'(paddle1), c);
    send(8'h1B, 1'b1, 1'b1);
    cyc(10);
    a = int'(paddle1);
    cyc(50);
    chk("s_down_5ticks", int'(paddle1), a + 20);

    // W+S together hold; paddle2 saturates at 400
    do_reset();
    send(8'h1D, 1'b1, 1'b1);
    send(8'h1B, 1'b1, 1'b1);
    cyc(10);
    a = int'(paddle1);
    cyc(100);
    chk("ws_hold", int'(paddle1), a);
    send(8'hE0, 1'b1, 1'b1);
    send(8'h72, 1'b1, 1'b1);
    cyc(10);
    b = int'(paddle2);
    cyc(50);
    chk("dn_5ticks", int'(paddle2), b + 20);
    cyc(600);
    chk("dn_sat_max", int'(paddle2), 400);
    chk("dn_p1_same", int'(paddle1), a);
    chk("p2_never_over", max_p2, 400);

    // bad stop bit, then truncated frame, then a good frame
    do_reset();
    send(8'h1D, 1'b1, 1'b1);
    send(8'h1B, 1'b1, 1'b1);
    cyc(10);
    a = int'(paddle1);
    send(8'hF0, 1'b1, 1'b1);
    f0 = fe_cnt;
    send(8'h1D, 1'b1, 1'b0);
    chk("stop_err_pulse", fe_cnt - f0, 1);
    cyc(100);
    chk("stop_err_keys", int'(paddle1), a);
    f0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    e = 0;
    while (fe_cnt == f0 && e < 200) begin
      @(negedge clk);
      e++;
    end
    chk("tmo_pulse", fe_cnt - f0, 1);
    chk("tmo_latency_ok", int'(e >= 25 && e <= 45), 1);
    cyc(20);
    chk("tmo_single", fe_cnt - f0, 1);
    send(8'h1D, 1'b1, 1'b1);
    cyc(10);
    a = int'(paddle1);
    cyc(50);
    chk("after_tmo_frame", int'(paddle1), a + 20);

    // even-parity W make
    do_reset();
    f0 = fe_cnt;
    send(8'h1D, 1'b0, 1'b1);
    cyc(10);
    a = int'(paddle1);
    cyc(50);
`ifdef PS2_PARITY_CHK_EN
    chk("par_err_pulse", fe_cnt - f0, 1);
    chk("par_no_move", int'(paddle1), 200);
`else
    chk("par_ignored_err", fe_cnt - f0, 0);
    chk("par_ignored_move", int'(paddle1), a - 20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
